// File: rtl/victim_cache_pkg.sv
// Shared types for the victim cache controller: FSM state encoding and way index type.
package victim_cache_pkg;

    localparam int VC_TAG_WIDTH = 4;
    localparam int VC_NUM_WAYS  = 4;
    localparam int VC_WAY_W     = $clog2(VC_NUM_WAYS);

    typedef logic [VC_WAY_W-1:0] way_idx_t;

    typedef enum logic [3:0] {
        IDLE,
        LK_ISSUE,
        LK_EVAL,
        LK_INV,
        INS_RD,
        INS_EVAL,
        INS_WB,
        INS_WR,
        INS_DIRTY
    } vc_state_e;

    // A victim needs a writeback only if it holds live, modified data.
    function automatic logic needs_writeback(input logic valid, input logic dirty);
        return valid & dirty;
    endfunction

endpackage

// File: rtl/victim_repl_ptr.sv
// Round-robin replacement pointer: a modulo-NUM_WAYS counter that steps on advance.
module victim_repl_ptr #(
    parameter  int NUM_WAYS = 4,
    localparam int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    output logic [WAY_W-1:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (ptr == WAY_W'(NUM_WAYS - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/victim_cache_ctrl.sv
// Victim cache tag-store sequencer: serialises L1-miss lookups and L1-evict inserts,
// chooses victims round-robin and hands dirty victims to the writeback path.
module victim_cache_ctrl
    import victim_cache_pkg::*;
#(
    parameter  int TAG_WIDTH = VC_TAG_WIDTH,
    parameter  int NUM_WAYS  = VC_NUM_WAYS,
    localparam int WAY_W     = $clog2(NUM_WAYS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [TAG_WIDTH-1:0] req_tag,
    output logic                 resp_valid,
    output logic                 resp_hit,
    output logic [WAY_W-1:0]     resp_way,
    input  logic                 ins_valid,
    output logic                 ins_ready,
    input  logic [TAG_WIDTH-1:0] ins_tag,
    input  logic                 ins_dirty,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [TAG_WIDTH-1:0] wb_tag,
    output logic [WAY_W-1:0]     wb_way,
    output logic                 ts_write_en,
    output logic                 ts_read_en,
    output logic                 ts_lookup_en,
    output logic                 ts_valid_clear,
    output logic                 ts_dirty_set,
    output logic                 ts_dirty_clear,
    output logic [TAG_WIDTH-1:0] ts_tag,
    output logic [WAY_W-1:0]     ts_way,
    input  logic                 ts_hit,
    input  logic [WAY_W-1:0]     ts_hit_way,
    input  logic                 ts_valid_read,
    input  logic                 ts_dirty_read,
    input  logic [TAG_WIDTH-1:0] ts_tag_read
);

    vc_state_e        state;
    logic [WAY_W-1:0] repl_ptr;
    logic             ins_dirty_q;
    logic             lk_accept;
    logic             ins_accept;

    victim_repl_ptr #(.NUM_WAYS(NUM_WAYS)) u_repl_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (state == INS_WR),
        .ptr     (repl_ptr)
    );

    // Lookups take priority over inserts when both arrive in the same idle cycle.
    assign req_ready  = rst_n && (state == IDLE);
    assign ins_ready  = req_ready && !req_valid;
    assign lk_accept  = req_valid && req_ready;
    assign ins_accept = ins_valid && ins_ready;

    // A miss is only known once the tag store answers, so it is reported in LK_EVAL directly.
    assign resp_valid = ((state == LK_EVAL) && !ts_hit) || (state == LK_INV);
    assign resp_hit   = (state == LK_INV);
    assign resp_way   = (state == LK_INV) ? ts_way : '0;

    assign ts_dirty_clear = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            ins_dirty_q    <= 1'b0;
            wb_valid       <= 1'b0;
            wb_tag         <= '0;
            wb_way         <= '0;
            ts_write_en    <= 1'b0;
            ts_read_en     <= 1'b0;
            ts_lookup_en   <= 1'b0;
            ts_valid_clear <= 1'b0;
            ts_dirty_set   <= 1'b0;
            ts_tag         <= '0;
            ts_way         <= '0;
        end else begin
            ts_write_en    <= 1'b0;
            ts_read_en     <= 1'b0;
            ts_lookup_en   <= 1'b0;
            ts_valid_clear <= 1'b0;
            ts_dirty_set   <= 1'b0;

            case (state)
                IDLE: begin
                    if (lk_accept) begin
                        state        <= LK_ISSUE;
                        ts_lookup_en <= 1'b1;
                        ts_tag       <= req_tag;
                        ts_way       <= '0;
                    end else if (ins_accept) begin
                        state       <= INS_RD;
                        ts_read_en  <= 1'b1;
                        ts_tag      <= ins_tag;
                        ts_way      <= repl_ptr;
                        ins_dirty_q <= ins_dirty;
                    end
                end

                LK_ISSUE: state <= LK_EVAL;

                // The cache is exclusive: a hit line returns to L1 and leaves this store.
                LK_EVAL: begin
                    if (ts_hit) begin
                        state          <= LK_INV;
                        ts_way         <= ts_hit_way;
                        ts_valid_clear <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        ts_tag <= '0;
                        ts_way <= '0;
                    end
                end

                LK_INV: begin
                    state  <= IDLE;
                    ts_tag <= '0;
                    ts_way <= '0;
                end

                INS_RD: state <= INS_EVAL;

                INS_EVAL: begin
                    if (needs_writeback(ts_valid_read, ts_dirty_read)) begin
                        state    <= INS_WB;
                        wb_valid <= 1'b1;
                        wb_tag   <= ts_tag_read;
                        wb_way   <= repl_ptr;
                    end else begin
                        state       <= INS_WR;
                        ts_write_en <= 1'b1;
                    end
                end

                // The victim is overwritten only after the writeback path has taken it.
                INS_WB: begin
                    if (wb_ready) begin
                        state       <= INS_WR;
                        wb_valid    <= 1'b0;
                        wb_tag      <= '0;
                        wb_way      <= '0;
                        ts_write_en <= 1'b1;
                    end
                end

                INS_WR: begin
                    ins_dirty_q <= 1'b0;
                    if (ins_dirty_q) begin
                        state        <= INS_DIRTY;
                        ts_dirty_set <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        ts_tag <= '0;
                        ts_way <= '0;
                    end
                end

                INS_DIRTY: begin
                    state  <= IDLE;
                    ts_tag <= '0;
                    ts_way <= '0;
                end

                default: begin
                    state  <= IDLE;
                    ts_tag <= '0;
                    ts_way <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_victim_cache_ctrl.sv
// Self-checking bench for victim_cache_ctrl with a behavioural tag store and
// queue-based scoreboards for lookup responses and tag-store writes.
module tb_victim_cache_ctrl;
    import victim_cache_pkg::*;

    localparam int TW = 4;
    localparam int NW = 4;
    localparam int WW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, resp_valid, resp_hit;
    logic [TW-1:0] req_tag;
    logic [WW-1:0] resp_way;
    logic          ins_valid, ins_ready, ins_dirty;
    logic [TW-1:0] ins_tag;
    logic          wb_valid, wb_ready;
    logic [TW-1:0] wb_tag;
    logic [WW-1:0] wb_way;
    logic          ts_write_en, ts_read_en, ts_lookup_en, ts_valid_clear, ts_dirty_set, ts_dirty_clear;
    logic [TW-1:0] ts_tag, ts_tag_read;
    logic [WW-1:0] ts_way, ts_hit_way;
    logic          ts_hit, ts_valid_read, ts_dirty_read;

    always #5 clk = ~clk;

    victim_cache_ctrl #(.TAG_WIDTH(TW), .NUM_WAYS(NW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_tag(ins_tag), .ins_dirty(ins_dirty),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_way(wb_way),
        .ts_write_en(ts_write_en), .ts_read_en(ts_read_en), .ts_lookup_en(ts_lookup_en),
        .ts_valid_clear(ts_valid_clear), .ts_dirty_set(ts_dirty_set), .ts_dirty_clear(ts_dirty_clear),
        .ts_tag(ts_tag), .ts_way(ts_way),
        .ts_hit(ts_hit), .ts_hit_way(ts_hit_way),
        .ts_valid_read(ts_valid_read), .ts_dirty_read(ts_dirty_read), .ts_tag_read(ts_tag_read)
    );

    // Behavioural tag store: results appear the cycle after the enable, writes mark valid/clean.
    logic [TW-1:0] m_tag   [NW];
    logic          m_valid [NW];
    logic          m_dirty [NW];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) begin
                m_tag[i]   <= '0;
                m_valid[i] <= 1'b0;
                m_dirty[i] <= 1'b0;
            end
            ts_hit        <= 1'b0;
            ts_hit_way    <= '0;
            ts_valid_read <= 1'b0;
            ts_dirty_read <= 1'b0;
            ts_tag_read   <= '0;
        end else begin
            if (ts_lookup_en) begin
                ts_hit     <= 1'b0;
                ts_hit_way <= '0;
                for (int i = 0; i < NW; i++) begin
                    if (m_valid[i] && m_tag[i] == ts_tag) begin
                        ts_hit     <= 1'b1;
                        ts_hit_way <= WW'(i);
                    end
                end
            end
            if (ts_read_en) begin
                ts_valid_read <= m_valid[ts_way];
                ts_dirty_read <= m_dirty[ts_way];
                ts_tag_read   <= m_tag[ts_way];
            end
            if (ts_write_en) begin
                m_tag[ts_way]   <= ts_tag;
                m_valid[ts_way] <= 1'b1;
                m_dirty[ts_way] <= 1'b0;
            end
            if (ts_valid_clear) m_valid[ts_way] <= 1'b0;
            if (ts_dirty_set)   m_dirty[ts_way] <= 1'b1;
        end
    end

    typedef struct {
        logic [TW-1:0] tag;
        way_idx_t      way;
    } wr_exp_t;

    typedef struct {
        logic     hit;
        way_idx_t way;
        int       lat;
    } resp_exp_t;

    wr_exp_t   exp_wr_q[$];
    resp_exp_t exp_resp_q[$];
    wr_exp_t   mon_e;

    logic [TW-1:0] sh_tag   [NW];
    logic          sh_valid [NW];
    logic          sh_dirty [NW];
    int            exp_ptr;

    int checks = 0;
    int errors = 0;

    task automatic check_output(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic clear_shadow();
        for (int i = 0; i < NW; i++) begin
            sh_tag[i]   = '0;
            sh_valid[i] = 1'b0;
            sh_dirty[i] = 1'b0;
        end
        exp_ptr = 0;
    endtask

    // Every tag-store write is matched against the next expected insert.
    always @(negedge clk) begin
        if (rst_n && ts_write_en === 1'b1) begin
            if (exp_wr_q.size() == 0) begin
                check_output("unexpected_write", 32'd1, 32'd0);
            end else begin
                mon_e = exp_wr_q.pop_front();
                check_output("write_tag", ts_tag, mon_e.tag);
                check_output("write_way", ts_way, mon_e.way);
            end
        end
    end

    task automatic do_lookup(input logic [TW-1:0] tag);
        resp_exp_t e;
        int        lat;
        int        n;
        bit        got;
        bit        clr_seen;
        way_idx_t  clr_way;
        e.hit = 1'b0;
        e.way = '0;
        for (int i = 0; i < NW; i++) begin
            if (sh_valid[i] && sh_tag[i] == tag) begin
                e.hit = 1'b1;
                e.way = WW'(i);
            end
        end
        e.lat = e.hit ? 3 : 2;
        exp_resp_q.push_back(e);
        req_valid = 1'b1;
        req_tag   = tag;
        #1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) check_output("lookup_accept_timeout", 32'd0, 32'd1);
        if (ins_valid) check_output("ins_ready_blocked", ins_ready, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1; got = 1'b0; clr_seen = 1'b0; clr_way = '0;
        while (!got && lat < 10) begin
            if (ts_valid_clear) begin
                clr_seen = 1'b1;
                clr_way  = ts_way;
            end
            if (resp_valid) begin
                got = 1'b1;
                e   = exp_resp_q.pop_front();
                check_output("resp_hit", resp_hit, e.hit);
                check_output("resp_latency", lat, e.lat);
                if (e.hit) check_output("resp_way", resp_way, e.way);
            end else begin
                @(posedge clk); #1; lat++;
            end
        end
        if (!got) begin
            check_output("lookup_resp_timeout", 32'd0, 32'd1);
        end else begin
            check_output("valid_clear_seen", clr_seen, e.hit);
            if (e.hit) begin
                check_output("valid_clear_way", clr_way, e.way);
                sh_valid[e.way] = 1'b0;
            end
        end
    endtask

    task automatic do_insert(input logic [TW-1:0] tag, input bit dirty, input int stall);
        wr_exp_t       w;
        int            way;
        bit            exp_wb;
        logic [TW-1:0] exp_wb_tag;
        int            extra;
        int            n, lat, wr_lat, ds_lat, wb_cycles, left;
        bit            done;
        way        = exp_ptr;
        exp_wb     = sh_valid[way] && sh_dirty[way];
        exp_wb_tag = sh_tag[way];
        extra      = exp_wb ? stall + 1 : 0;
        w.tag = tag;
        w.way = WW'(way);
        exp_wr_q.push_back(w);
        ins_valid = 1'b1;
        ins_tag   = tag;
        ins_dirty = dirty;
        #1;
        n = 0;
        while (!ins_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) check_output("insert_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        ins_valid = 1'b0;
        lat = 1; wr_lat = 0; ds_lat = 0; wb_cycles = 0; left = stall; done = 1'b0;
        while (!done && lat < 40) begin
            wb_ready = 1'b0;
            if (ts_write_en) wr_lat = lat;
            if (ts_dirty_set) begin
                ds_lat = lat;
                check_output("dirty_set_way", ts_way, way);
            end
            if (wb_valid) begin
                wb_cycles++;
                check_output("wb_tag", wb_tag, exp_wb_tag);
                check_output("wb_way", wb_way, way);
                if (left > 0) left--;
                else wb_ready = 1'b1;
            end
            if (req_ready) done = 1'b1;
            else begin
                @(posedge clk); #1; lat++;
            end
        end
        wb_ready = 1'b0;
        check_output("insert_done_seen", done, 32'd1);
        check_output("wb_cycles", wb_cycles, exp_wb ? stall + 1 : 0);
        check_output("write_latency", wr_lat, 3 + extra);
        check_output("dirty_set_latency", ds_lat, dirty ? 3 + extra + 1 : 0);
        check_output("insert_latency", lat, 4 + (dirty ? 1 : 0) + extra);
        sh_tag[way]   = tag;
        sh_valid[way] = 1'b1;
        sh_dirty[way] = dirty;
        exp_ptr       = (exp_ptr + 1) % NW;
    endtask

    task automatic check_all_quiet(input string where);
        check_output({where, "_req_ready"}, req_ready, 32'd0);
        check_output({where, "_ins_ready"}, ins_ready, 32'd0);
        check_output({where, "_resp"}, {resp_valid, resp_hit, resp_way}, 32'd0);
        check_output({where, "_wb"}, {wb_valid, wb_tag, wb_way}, 32'd0);
        check_output({where, "_ts_en"}, {ts_write_en, ts_read_en, ts_lookup_en,
                     ts_valid_clear, ts_dirty_set, ts_dirty_clear}, 32'd0);
        check_output({where, "_ts_operands"}, {ts_tag, ts_way}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        req_valid = 1'b0; req_tag = '0;
        ins_valid = 1'b0; ins_tag = '0; ins_dirty = 1'b0;
        wb_ready = 1'b0;
        clear_shadow();
        repeat (3) @(posedge clk);
        #1;
        check_all_quiet("reset");
        rst_n = 1'b1;
        #1;
        check_output("post_reset_req_ready", req_ready, 32'd1);
        check_output("post_reset_ins_ready", ins_ready, 32'd1);
        @(posedge clk); #1;

        $display("[TB] clean inserts into ways 0..2");
        do_insert(4'hA, 1'b0, 0);
        do_insert(4'hB, 1'b0, 0);
        do_insert(4'hC, 1'b0, 0);

        $display("[TB] lookup hit then repeat lookup miss");
        do_lookup(4'hB);
        do_lookup(4'hB);

        $display("[TB] dirty insert, pointer wrap, stalled writeback");
        do_insert(4'hD, 1'b1, 0);
        do_insert(4'hE, 1'b0, 0);
        do_insert(4'hF, 1'b0, 0);
        do_insert(4'h1, 1'b0, 0);
        do_insert(4'h2, 1'b0, 3);

        $display("[TB] simultaneous lookup and insert");
        ins_valid = 1'b1; ins_tag = 4'h3; ins_dirty = 1'b0;
        do_lookup(4'hE);
        do_insert(4'h3, 1'b0, 0);

        $display("[TB] reset during writeback");
        do_insert(4'h4, 1'b1, 0);
        do_insert(4'h5, 1'b0, 0);
        do_insert(4'h6, 1'b0, 0);
        do_insert(4'h7, 1'b0, 0);
        ins_valid = 1'b1; ins_tag = 4'h8; ins_dirty = 1'b0;
        #1;
        n = 0;
        while (!ins_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        ins_valid = 1'b0;
        wb_ready  = 1'b0;
        n = 0;
        while (!wb_valid && n < 10) begin
            @(posedge clk); #1; n++;
        end
        check_output("abort_wb_valid", wb_valid, 32'd1);
        check_output("abort_wb_tag", wb_tag, 32'h4);
        check_output("abort_wb_way", wb_way, 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_quiet("async_reset");
        @(posedge clk); #1;
        check_output("held_reset_wb_valid", wb_valid, 32'd0);
        rst_n = 1'b1;
        #1;
        check_output("release_req_ready", req_ready, 32'd1);
        check_output("release_ins_ready", ins_ready, 32'd1);
        clear_shadow();
        @(posedge clk); #1;

        $display("[TB] lookup on empty cache and pointer restart");
        do_lookup(4'hF);
        do_insert(4'h9, 1'b0, 0);
        do_lookup(4'h9);

        repeat (2) @(posedge clk);
        #1;
        check_output("write_queue_drained", exp_wr_q.size(), 32'd0);
        check_output("resp_queue_drained", exp_resp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
